// File: rtl/regfile_write_arbiter_if.sv
// Bus between the register-file write requesters and the write arbiter.
// The master side raises requests and the slave side returns grants and the registered write.
interface regfile_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] data;
  logic                    hold;
  logic [N_REQ-1:0]        gnt;
  logic                    wr_valid;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [(2**ADDR_W)-1:0]  we;

  modport master (
    output req, lock, addr, data, hold,
    input  gnt, wr_valid, wr_addr, wr_data, we
  );

  modport slave (
    input  req, lock, addr, data, hold,
    output gnt, wr_valid, wr_addr, wr_data, we
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with burst locking.
// The grant is combinational; the winning write is registered one cycle later with a one-hot enable.
module regfile_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input logic                    clk_i,
  input logic                    reset_i,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WE_W  = 2**ADDR_W;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  owner_q;
  logic              wrValid_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [DATA_W-1:0] wrData_q;
  logic [WE_W-1:0]   we_q;

  logic              gntAny;
  logic [PTR_W-1:0]  gntIdx;
  logic [PTR_W-1:0]  ptr_d;
  logic [ADDR_W-1:0] wrAddr_d;
  logic [DATA_W-1:0] wrData_d;
  logic [WE_W-1:0]   we_d;
  int                scanIdx;
  logic [PTR_W-1:0]  candIdx;

  // Scanning from the far end down lets the requester closest to ptr win by assigning last.
  always_comb begin
    gntAny  = 1'b0;
    gntIdx  = '0;
    scanIdx = 0;
    candIdx = '0;
    if (!reset_i && !bus.hold) begin
      if (state_q == IDLE) begin
        for (int k = N_REQ - 1; k >= 0; k--) begin
          scanIdx = int'(ptr_q) + k;
          if (scanIdx >= N_REQ) begin
            scanIdx = scanIdx - N_REQ;
          end
          candIdx = PTR_W'(scanIdx);
          if (bus.req[candIdx]) begin
            gntAny = 1'b1;
            gntIdx = candIdx;
          end
        end
      end else if (bus.req[owner_q]) begin
        gntAny = 1'b1;
        gntIdx = owner_q;
      end
    end
  end

  always_comb begin
    wrAddr_d = '0;
    wrData_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gntIdx == PTR_W'(i)) begin
        wrAddr_d = bus.addr[i*ADDR_W +: ADDR_W];
        wrData_d = bus.data[i*DATA_W +: DATA_W];
      end
    end
    we_d = WE_W'(1) << wrAddr_d;
    if (gntIdx == PTR_W'(N_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gntIdx + PTR_W'(1);
    end
  end

  assign bus.gnt      = gntAny ? (N_REQ'(1) << gntIdx) : '0;
  assign bus.wr_valid = wrValid_q;
  assign bus.wr_addr  = wrAddr_q;
  assign bus.wr_data  = wrData_q;
  assign bus.we       = we_q;

  // Without a grant only the enable drops; address and data keep their last written value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      wrValid_q <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      we_q      <= '0;
    end else begin
      wrValid_q <= gntAny;
      if (gntAny) begin
        wrAddr_q <= wrAddr_d;
        wrData_q <= wrData_d;
        we_q     <= we_d;
      end else begin
        we_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (gntAny) begin
            ptr_q <= ptr_d;
            if (bus.lock[gntIdx]) begin
              owner_q <= gntIdx;
              state_q <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (!bus.req[owner_q] || (gntAny && !bus.lock[owner_q])) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: grants are checked in-cycle, and writes are
// checked against a queue of expected writes by an independent monitor.
module tb_regfile_write_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  wr_t               expQ[$];
  logic [ADDR_W-1:0] addrV[N_REQ];
  logic [DATA_W-1:0] dataV[N_REQ];
  int                nChecks = 0;
  int                nFails  = 0;
  bit                monOn   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setSlot(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    addrV[i] = a;
    dataV[i] = d;
  endtask

  // One cycle: drive just after the rising edge, check the grant at the falling edge.
  task automatic applyStimulus(input logic rst, input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] l,
                               input logic h, input logic [N_REQ-1:0] expGnt, input string name);
    wr_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    bus.req  = r;
    bus.lock = l;
    bus.hold = h;
    for (int i = 0; i < N_REQ; i++) begin
      bus.addr[i*ADDR_W +: ADDR_W] = addrV[i];
      bus.data[i*DATA_W +: DATA_W] = dataV[i];
    end
    @(negedge clk);
    checkOutput(name, 32'(bus.gnt), 32'(expGnt));
    for (int i = 0; i < N_REQ; i++) begin
      if (expGnt[i]) begin
        e.addr = addrV[i];
        e.data = dataV[i];
        expQ.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (monOn) begin
      if (bus.wr_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpectedWrite: got wr_valid=1 addr=%h, expected no write", bus.wr_addr);
        end else begin
          e = expQ.pop_front();
          checkOutput("wrAddr", 32'(bus.wr_addr), 32'(e.addr));
          checkOutput("wrData", bus.wr_data, e.data);
          checkOutput("weOneHot", 32'(bus.we), 32'(16'h0001 << e.addr));
        end
      end else begin
        checkOutput("weIdle", 32'(bus.we), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req  = '0;
    bus.lock = '0;
    bus.hold = 1'b0;
    bus.addr = '0;
    bus.data = '0;
    for (int i = 0; i < N_REQ; i++) setSlot(i, ADDR_W'(i + 1), 32'h1000_0000 + 32'(i));

    // Reset with all requesting, then plain round-robin with a wrap.
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, "gntInReset0");
    monOn = 1'b1;
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, "gntInReset1");
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, "rr0");
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0010, "rr1");
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0100, "rr2");
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1000, "rr3");
    applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, "rrWrap");

    // Single write to the top register.
    setSlot(2, 4'hF, 32'hDEADBEEF);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, "single2");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, "idleAfterSingle");
    checkOutput("singleValid", 32'(bus.wr_valid), 32'h1);
    checkOutput("singleAddr", 32'(bus.wr_addr), 32'hF);
    checkOutput("singleWe", 32'(bus.we), 32'h8000);
    checkOutput("singleData", bus.wr_data, 32'hDEADBEEF);

    // Four-beat locked burst from requester 1 while requester 0 waits.
    setSlot(0, 4'hA, 32'h0000_A0A0);
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, "prepPtr");
    setSlot(1, 4'h5, 32'hB000_0001);
    applyStimulus(1'b0, 4'b0011, 4'b0010, 1'b0, 4'b0010, "burst1");
    setSlot(1, 4'h6, 32'hB000_0002);
    applyStimulus(1'b0, 4'b0011, 4'b0010, 1'b0, 4'b0010, "burst2");
    setSlot(1, 4'h7, 32'hB000_0003);
    applyStimulus(1'b0, 4'b0011, 4'b0010, 1'b0, 4'b0010, "burst3");
    setSlot(1, 4'h8, 32'hB000_0004);
    applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0010, "burstLast");
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, "afterBurst");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, "idle3");

    // Hold blocks grants without moving the pointer.
    applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0000, "hold0");
    applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0000, "hold1");
    applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0010, "afterHold");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, "idle4");

    // Burst owner abandons; requester 3 goes next.
    setSlot(2, 4'hB, 32'hC000_0002);
    setSlot(3, 4'hC, 32'hC000_0003);
    applyStimulus(1'b0, 4'b1100, 4'b0100, 1'b0, 4'b0100, "lock2a");
    applyStimulus(1'b0, 4'b1100, 4'b0100, 1'b0, 4'b0100, "lock2b");
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0, 4'b0000, "abandon");
    applyStimulus(1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, "waiter3");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, "idle5");

    // Reset arrives mid-burst.
    setSlot(0, 4'hD, 32'hD000_0000);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0001, "lock0");
    applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, "resetInLock");
    applyStimulus(1'b0, 4'b1001, 4'b0000, 1'b0, 4'b0001, "afterReset");
    checkOutput("rstValid", 32'(bus.wr_valid), 32'h0);
    checkOutput("rstWe", 32'(bus.we), 32'h0);

    // Two requesters writing the same register land in grant order.
    setSlot(0, 4'h9, 32'h0000_0111);
    setSlot(1, 4'h9, 32'h0000_0222);
    applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0010, "sameReg1");
    applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, "sameReg0");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, "idle6");
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, "idle7");
    checkOutput("lastWinsData", bus.wr_data, 32'h0000_0111);
    checkOutput("queueDrained", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
